// File: rtl/vend_dispenser.sv
// rtl/vend_dispenser.sv - product/coin dispenser sequencer with pending-request counters
// Services queued product, 10-rupee and 5-rupee requests one at a time; overflow forces FAULT.
module vend_dispenser #(
    parameter int MOTOR_CYCLES = 8,
    parameter int PULSE_CYCLES = 2,
    parameter int GAP_CYCLES   = 2,
    parameter int DROP_TIMEOUT = 32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       out,
    input  logic       change5,
    input  logic       change10,
    input  logic       drop_sense,
    input  logic       fault_clr,
    output logic       motor_on,
    output logic       eject5,
    output logic       eject10,
    output logic       busy,
    output logic       fault,
    output logic [2:0] pend_prod,
    output logic [2:0] pend5,
    output logic [2:0] pend10
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_MOTOR,
        S_WAIT_DROP,
        S_EJECT5,
        S_EJECT10,
        S_GAP,
        S_FAULT
    } state_t;

    localparam logic [7:0] MOTOR_LAST = 8'(MOTOR_CYCLES - 1);
    localparam logic [7:0] PULSE_LAST = 8'(PULSE_CYCLES - 1);
    localparam logic [7:0] GAP_LAST   = 8'(GAP_CYCLES - 1);
    localparam logic [7:0] DROP_LAST  = 8'(DROP_TIMEOUT - 1);

    state_t     state_q, state_d;
    logic [7:0] timer_q, timer_d;
    logic [2:0] pend_prod_q, pend_prod_d;
    logic [2:0] pend5_q, pend5_d;
    logic [2:0] pend10_q, pend10_d;
    logic       motor_on_q, motor_on_d;
    logic       eject5_q, eject5_d;
    logic       eject10_q, eject10_d;

    logic sel_prod, sel10, sel5;
    logic dec_prod, dec10, dec5;
    logic ovf;

    function automatic logic [2:0] cnt_next(input logic [2:0] c, input logic inc, input logic dec);
        if (inc && !dec && c != 3'd7) return c + 3'd1;
        if (dec && !inc)              return c - 3'd1;
        return c;
    endfunction

    // Selection depends only on counts, so the overflow test can exempt the
    // counter being serviced this cycle (its increment is absorbed by the decrement).
    always_comb begin
        sel_prod = (state_q == S_IDLE) && (pend_prod_q != 3'd0);
        sel10    = (state_q == S_IDLE) && (pend_prod_q == 3'd0) && (pend10_q != 3'd0);
        sel5     = (state_q == S_IDLE) && (pend_prod_q == 3'd0) && (pend10_q == 3'd0)
                   && (pend5_q != 3'd0);
        ovf      = (out      && pend_prod_q == 3'd7 && !sel_prod)
                 | (change10 && pend10_q    == 3'd7 && !sel10)
                 | (change5  && pend5_q     == 3'd7 && !sel5);
        dec_prod = sel_prod && !ovf;
        dec10    = sel10 && !ovf;
        dec5     = sel5 && !ovf;
        pend_prod_d = cnt_next(pend_prod_q, out, dec_prod);
        pend10_d    = cnt_next(pend10_q, change10, dec10);
        pend5_d     = cnt_next(pend5_q, change5, dec5);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            timer_q     <= 8'd0;
            pend_prod_q <= 3'd0;
            pend5_q     <= 3'd0;
            pend10_q    <= 3'd0;
            motor_on_q  <= 1'b0;
            eject5_q    <= 1'b0;
            eject10_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            pend_prod_q <= pend_prod_d;
            pend5_q     <= pend5_d;
            pend10_q    <= pend10_d;
            motor_on_q  <= motor_on_d;
            eject5_q    <= eject5_d;
            eject10_q   <= eject10_d;
        end
    end

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        case (state_q)
            S_IDLE: begin
                timer_d = 8'd0;
                if (dec_prod)   state_d = S_MOTOR;
                else if (dec10) state_d = S_EJECT10;
                else if (dec5)  state_d = S_EJECT5;
            end
            S_MOTOR: begin
                if (timer_q == MOTOR_LAST) begin
                    state_d = S_WAIT_DROP;
                    timer_d = 8'd0;
                end else begin
                    timer_d = timer_q + 8'd1;
                end
            end
            S_WAIT_DROP: begin
                if (drop_sense) begin
                    state_d = S_GAP;
                    timer_d = 8'd0;
                end else if (timer_q == DROP_LAST) begin
                    state_d = S_FAULT;
                    timer_d = 8'd0;
                end else begin
                    timer_d = timer_q + 8'd1;
                end
            end
            S_EJECT5, S_EJECT10: begin
                if (timer_q == PULSE_LAST) begin
                    state_d = S_GAP;
                    timer_d = 8'd0;
                end else begin
                    timer_d = timer_q + 8'd1;
                end
            end
            S_GAP: begin
                if (timer_q == GAP_LAST) begin
                    state_d = S_IDLE;
                    timer_d = 8'd0;
                end else begin
                    timer_d = timer_q + 8'd1;
                end
            end
            S_FAULT: begin
                timer_d = 8'd0;
                if (fault_clr) state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                timer_d = 8'd0;
            end
        endcase
        if (ovf) begin
            state_d = S_FAULT;
            timer_d = 8'd0;
        end
    end

    // Drives are decoded from the next state so the flops track the state register exactly.
    always_comb begin
        motor_on_d = (state_d == S_MOTOR);
        eject5_d   = (state_d == S_EJECT5);
        eject10_d  = (state_d == S_EJECT10);
    end

    assign motor_on  = motor_on_q;
    assign eject5    = eject5_q;
    assign eject10   = eject10_q;
    assign fault     = (state_q == S_FAULT);
    assign busy      = (state_q != S_IDLE) || (pend_prod_q != 3'd0)
                     || (pend5_q != 3'd0) || (pend10_q != 3'd0);
    assign pend_prod = pend_prod_q;
    assign pend5     = pend5_q;
    assign pend10    = pend10_q;

endmodule

// File: tb/tb_vend_dispenser.sv
// tb/tb_vend_dispenser.sv - directed table and sequence checks for vend_dispenser
module tb_vend_dispenser;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       out = 1'b0, change5 = 1'b0, change10 = 1'b0, drop_sense = 1'b0, fault_clr = 1'b0;
    logic       motor_on, eject5, eject10, busy, fault;
    logic [2:0] pend_prod, pend5, pend10;

    int checks = 0;
    int failures = 0;

    vend_dispenser dut (
        .clk(clk), .rst(rst), .out(out), .change5(change5), .change10(change10),
        .drop_sense(drop_sense), .fault_clr(fault_clr), .motor_on(motor_on),
        .eject5(eject5), .eject10(eject10), .busy(busy), .fault(fault),
        .pend_prod(pend_prod), .pend5(pend5), .pend10(pend10)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        o, c5, c10, d, fc;
        logic [13:0] exp;
    } vec_t;

    function automatic logic [13:0] ev(input logic m, input logic e5, input logic e10,
                                       input logic b, input logic f, input logic [2:0] pp,
                                       input logic [2:0] p5, input logic [2:0] p10);
        return {m, e5, e10, b, f, pp, p5, p10};
    endfunction

    function automatic logic [13:0] outv();
        return {motor_on, eject5, eject10, busy, fault, pend_prod, pend5, pend10};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic step(input logic o, input logic c5, input logic c10, input logic d,
                        input logic fc, input logic r);
        @(negedge clk);
        out = o; change5 = c5; change10 = c10; drop_sense = d; fault_clr = fc; rst = r;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_steps(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 1);
    endtask

    vec_t tbl[15];
    int   cnt;
    logic prev;

    initial begin
        // single product; drop_sense during MOTOR (row 4) must be ignored
        tbl[0] = '{1, 0, 0, 0, 0, ev(0, 0, 0, 1, 0, 3'd1, 3'd0, 3'd0)};
        for (int i = 1; i <= 8; i++)
            tbl[i] = '{0, 0, 0, (i == 4), 0, ev(1, 0, 0, 1, 0, 3'd0, 3'd0, 3'd0)};
        for (int i = 9; i <= 13; i++)
            tbl[i] = '{0, 0, 0, (i == 12), 0, ev(0, 0, 0, 1, 0, 3'd0, 3'd0, 3'd0)};
        tbl[14] = '{0, 0, 0, 0, 0, ev(0, 0, 0, 0, 0, 3'd0, 3'd0, 3'd0)};

        step(1, 1, 1, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        check("reset_state", 32'(outv()), 32'd0);
        step(0, 0, 0, 0, 1, 1);
        check("fault_clr_idle_ignored", 32'(outv()), 32'd0);

        for (int i = 0; i < 15; i++) begin
            step(tbl[i].o, tbl[i].c5, tbl[i].c10, tbl[i].d, tbl[i].fc, 1);
            check($sformatf("single_row%0d", i), 32'(outv()), 32'(tbl[i].exp));
        end

        // mixed burst with drop_sense held high
        for (int k = 1; k <= 24; k++) begin
            step(k == 1, k == 1, k == 1, 1, 0, 1);
            check($sformatf("burst_k%0d", k), {28'd0, motor_on, eject10, eject5, busy},
                  {28'd0, (k >= 2 && k <= 9), (k >= 14 && k <= 15), (k >= 19 && k <= 20), (k < 23)});
        end

        // same-cycle increment and decrement on pend5
        step(0, 1, 0, 0, 0, 1);
        step(0, 1, 0, 0, 0, 1);
        check("incdec_k2", {30'd0, eject5, pend5 == 3'd1}, {30'd0, 1'b1, 1'b1});
        idle_steps(4);
        check("incdec_k6", {29'd0, eject5, pend5}, {29'd0, 1'b0, 3'd1});
        step(0, 0, 0, 0, 0, 1);
        check("incdec_k7", {29'd0, eject5, pend5}, {29'd0, 1'b1, 3'd0});
        idle_steps(6);
        check("incdec_done", 32'(outv()), 32'd0);

        // drop timeout: WAIT_DROP entered at edge 10, FAULT at edge 42
        step(1, 0, 0, 0, 0, 1);
        for (int k = 2; k <= 42; k++) begin
            step(0, 0, 0, 0, 0, 1);
            if (k == 41) check("timeout_k41", 32'(fault), 32'd0);
            if (k == 42) check("timeout_k42", 32'(outv()), 32'(ev(0, 0, 0, 1, 1, 3'd0, 3'd0, 3'd0)));
        end

        // saturation while in FAULT
        for (int i = 0; i < 8; i++) step(0, 1, 0, 0, 0, 1);
        check("sat_pend5", 32'(outv()), 32'(ev(0, 0, 0, 1, 1, 3'd0, 3'd7, 3'd0)));
        step(0, 0, 0, 0, 1, 1);
        check("sat_fault_clr", 32'(fault), 32'd0);
        cnt = 0;
        prev = 1'b0;
        for (int i = 0; i < 50; i++) begin
            step(0, 0, 0, 0, 0, 1);
            if (eject5 && !prev) cnt++;
            prev = eject5;
        end
        check("sat_eject_count", 32'(cnt), 32'd7);
        check("sat_drained", 32'(outv()), 32'd0);

        // overflow preempts a running motor
        for (int k = 1; k <= 9; k++) begin
            step(1, 0, 0, 0, 0, 1);
            if (k == 8) check("ovf_k8_motor", {31'd0, motor_on}, 32'd1);
        end
        check("ovf_k9", 32'(outv()), 32'(ev(0, 0, 0, 1, 1, 3'd7, 3'd0, 3'd0)));
        step(0, 0, 0, 0, 0, 0);
        check("ovf_reset", 32'(outv()), 32'd0);

        // reset during the first eject10 cycle discards the concurrent request
        step(0, 0, 1, 0, 0, 1);
        step(0, 0, 0, 0, 0, 1);
        check("rst_mid_eject_pre", 32'(outv()), 32'(ev(0, 0, 1, 1, 0, 3'd0, 3'd0, 3'd0)));
        step(0, 1, 0, 0, 0, 0);
        check("rst_mid_eject", 32'(outv()), 32'd0);
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            step(0, 0, 0, 0, 0, 1);
            if (outv() != 14'd0) cnt++;
        end
        check("rst_no_more_activity", 32'(cnt), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

endmodule

// File: doc/vend_dispenser.md
VEND_DISPENSER -- requirements
Module: vend_dispenser

Interface
REQ-001 The module SHALL have parameter MOTOR_CYCLES, default 8, giving the product motor on-time in clock cycles (legal range 1..255).
REQ-002 The module SHALL have parameter PULSE_CYCLES, default 2, giving the coin-eject pulse width in cycles (legal range 1..15).
REQ-003 The module SHALL have parameter GAP_CYCLES, default 2, giving the minimum idle cycles after each eject pulse (legal range 1..15).
REQ-004 The module SHALL have parameter DROP_TIMEOUT, default 32, giving the maximum cycles to wait for drop_sense after the motor stops (legal range 1..255).
REQ-005 The module SHALL have the port clk, input, 1 bit: the single clock; all logic is clocked on its rising edge.
REQ-006 The module SHALL have the port rst, input, 1 bit: synchronous, active-low reset.
REQ-007 The module SHALL have the port out, input, 1 bit: product-vend request, sampled every cycle; each high cycle is one request.
REQ-008 The module SHALL have the port change5, input, 1 bit: 5-rupee change request, sampled every cycle; each high cycle is one request.
REQ-009 The module SHALL have the port change10, input, 1 bit: 10-rupee change request, sampled every cycle; each high cycle is one request.
REQ-010 The module SHALL have the port drop_sense, input, 1 bit: high while the product-drop sensor detects an item.
REQ-011 The module SHALL have the port fault_clr, input, 1 bit: a one-cycle pulse that clears the fault condition.
REQ-012 The module SHALL have the port motor_on, output, 1 bit: product motor drive.
REQ-013 The module SHALL have the port eject5, output, 1 bit: 5-rupee hopper eject pulse.
REQ-014 The module SHALL have the port eject10, output, 1 bit: 10-rupee hopper eject pulse.
REQ-015 The module SHALL have the port busy, output, 1 bit: high when the state is not IDLE or any pending count is non-zero.
REQ-016 The module SHALL have the port fault, output, 1 bit: high while the state is FAULT.
REQ-017 The module SHALL have the ports pend_prod, pend5 and pend10, output, 3 bits each: the pending product, 5-rupee and 10-rupee request counts.

Function
REQ-018 The module SHALL keep three 3-bit pending counters, incremented by out, change5 and change10 respectively on each cycle the input is high.
REQ-019 Each counter SHALL saturate at 7; a request arriving at 7 SHALL be dropped and SHALL set the state to FAULT.
REQ-020 An increment and a service decrement on the same counter in the same cycle SHALL leave its value unchanged.
REQ-021 The FSM SHALL have exactly the states IDLE, MOTOR, WAIT_DROP, EJECT5, EJECT10, GAP and FAULT.
REQ-022 From IDLE, with service priority product > 10-rupee > 5-rupee, the FSM SHALL select the highest-priority non-zero counter, decrement it, and move next cycle to MOTOR, EJECT10 or EJECT5 respectively.
REQ-023 A counter SHALL be decremented in the IDLE cycle that selects it; a request arriving in that same cycle SHALL be counted per REQ-020.
REQ-024 In MOTOR, motor_on SHALL be high for exactly MOTOR_CYCLES cycles, after which the FSM SHALL enter WAIT_DROP.
REQ-025 In WAIT_DROP, drop_sense high SHALL cause a transition to GAP on the next edge.
REQ-026 If drop_sense has not been seen after DROP_TIMEOUT cycles in WAIT_DROP, the FSM SHALL enter FAULT.
REQ-027 A drop_sense pulse during MOTOR SHALL be ignored.
REQ-028 In EJECT5 or EJECT10, eject5 or eject10 respectively SHALL be high for exactly PULSE_CYCLES cycles, after which the FSM SHALL enter GAP.
REQ-029 eject5, eject10 and motor_on SHALL be mutually exclusive, and each SHALL be a registered output.
REQ-030 GAP SHALL last exactly GAP_CYCLES cycles, with all drive outputs low, then return to IDLE.
REQ-031 In FAULT, all drive outputs SHALL be low and fault high; pending counters SHALL keep their values and continue to accept requests up to saturation.
REQ-032 fault_clr in FAULT SHALL return the FSM to IDLE on the next edge; fault_clr in any other state SHALL be ignored.
REQ-033 An overflow that occurs in any state SHALL preempt the current operation: drive outputs SHALL go low on the next edge.
REQ-034 Request-to-first-drive latency from an idle module with all counters zero SHALL be 2 cycles: the counter updates at edge 1 and the drive output rises at edge 2.

Reset
REQ-035 When rst is low at a rising edge, the module SHALL set state to IDLE, all counters and timers to 0, and motor_on, eject5, eject10, busy and fault to 0, regardless of the current state, including mid-pulse.
REQ-036 Requests presented in a cycle where rst is low SHALL be discarded.

Verification
REQ-037 Single product: one-cycle out pulse, drop_sense 3 cycles after the motor stops -> motor_on high for 8 cycles, GAP 2 cycles, IDLE, busy low, pend_prod=0.
REQ-038 Mixed burst: out, change10 and change5 pulsed in the same cycle -> service order motor, eject10 (2 cycles), eject5 (2 cycles), with 2 GAP cycles after each.
REQ-039 Drop timeout: out pulse with no drop_sense -> fault=1 exactly 32 cycles after WAIT_DROP is entered; fault_clr -> IDLE next cycle.
REQ-040 Saturation: eight change5 pulses issued while in FAULT -> pend5=7 and the eighth request is dropped; after fault_clr, exactly 7 eject5 pulses follow.
REQ-041 Same-cycle increment/decrement: change5 pulse in the IDLE cycle that selects pend5=1 -> pend5 stays 1, and the second eject follows after GAP.
REQ-042 Reset mid-eject: rst low during the first eject10 cycle -> all outputs 0 and counters 0 at the next edge; no further ejects occur.
